// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back scheduler and its scoreboard.
package regfile_pkg;

    localparam int BIT_SIZE_DEF     = 32;
    localparam int REG_ADDR_W       = 5;
    localparam int NUM_REGS         = 32;
    localparam int STARVE_LIMIT_DEF = 3;
    // Wide enough for the largest legal starve_limit (15).
    localparam int STARVE_CNT_W     = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_A,
        GNT_B
    } grant_e;

    // r0 is hard-wired to zero, so it is never written and never tracked.
    function automatic logic is_r0(input reg_addr_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, with
// set on reservation, clear on Regfile write, and read-port hazard lookup.
module wb_scoreboard
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rsv_valid,
    input  logic [REG_ADDR_W-1:0] rsv_addr,
    output logic                  rsv_ready,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] Read_addr_1,
    input  logic [REG_ADDR_W-1:0] Read_addr_2,
    output logic                  stall_1,
    output logic                  stall_2
);

    logic [NUM_REGS-1:1] busy_q;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_d;
    logic                set_en;

    assign busy = {busy_q, 1'b0};

    assign rsv_ready = rst & ~busy[rsv_addr];
    assign set_en    = rsv_valid & rsv_ready & ~is_r0(rsv_addr);

    assign stall_1 = busy[Read_addr_1];
    assign stall_2 = busy[Read_addr_2];

    // Set is applied after clear, so a same-edge reservation keeps the register busy.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        busy_d = busy;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            busy_q <= busy_d[NUM_REGS-1:1];
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates ALU (A) and memory (B) results onto the single
// Regfile write port with B priority and starvation protection for A.
module regfile_wb_sched
    import regfile_pkg::*;
#(
    parameter int bit_size     = BIT_SIZE_DEF,
    parameter int starve_limit = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rsv_valid,
    input  logic [REG_ADDR_W-1:0] rsv_addr,
    output logic                  rsv_ready,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [bit_size-1:0]   a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [bit_size-1:0]   b_data,
    output logic                  b_ready,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] Write_addr,
    output logic [bit_size-1:0]   Write_data,
    input  logic [REG_ADDR_W-1:0] Read_addr_1,
    input  logic [REG_ADDR_W-1:0] Read_addr_2,
    output logic                  stall_1,
    output logic                  stall_2
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(starve_limit);

    logic [STARVE_CNT_W-1:0] starve_cnt;
    grant_e                  grant;
    logic                    xfer;
    logic [REG_ADDR_W-1:0]   xfer_addr;
    logic [bit_size-1:0]     xfer_data;

    // A only overrides B once it has been denied starve_limit cycles in a row.
    always_comb begin
        grant = GNT_NONE;
        if (rst) begin
            if (a_valid && starve_cnt == LIMIT) begin
                grant = GNT_A;
            end else if (b_valid) begin
                grant = GNT_B;
            end else if (a_valid) begin
                grant = GNT_A;
            end
        end
    end

    assign a_ready   = (grant == GNT_A);
    assign b_ready   = (grant == GNT_B);
    assign xfer      = a_ready | b_ready;
    assign xfer_addr = b_ready ? b_addr : a_addr;
    assign xfer_data = b_ready ? b_data : a_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!a_valid || a_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Address and data hold between transfers; only RegWrite pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite   <= 1'b0;
            Write_addr <= '0;
            Write_data <= '0;
        end else begin
            RegWrite <= xfer & ~is_r0(xfer_addr);
            if (xfer) begin
                Write_addr <= xfer_addr;
                Write_data <= xfer_data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .rsv_valid   (rsv_valid),
        .rsv_addr    (rsv_addr),
        .rsv_ready   (rsv_ready),
        .clr_en      (RegWrite),
        .clr_addr    (Write_addr),
        .Read_addr_1 (Read_addr_1),
        .Read_addr_2 (Read_addr_2),
        .stall_1     (stall_1),
        .stall_2     (stall_2)
    );

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: reservation/hazard flow, arbitration with
// starvation, reservation collisions, r0 handling and mid-operation reset.
module tb_regfile_wb_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        RegWrite;
    logic [4:0]  Write_addr;
    logic [31:0] Write_data;
    logic [4:0]  Read_addr_1;
    logic [4:0]  Read_addr_2;
    logic        stall_1;
    logic        stall_2;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_sched #(.bit_size(32), .starve_limit(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .rsv_valid   (rsv_valid),
        .rsv_addr    (rsv_addr),
        .rsv_ready   (rsv_ready),
        .a_valid     (a_valid),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .RegWrite    (RegWrite),
        .Write_addr  (Write_addr),
        .Write_data  (Write_data),
        .Read_addr_1 (Read_addr_1),
        .Read_addr_2 (Read_addr_2),
        .stall_1     (stall_1),
        .stall_2     (stall_2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        rsv_valid = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
    endtask

    bit exp_b [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        idle();
        rsv_addr = 5'd0; a_addr = 5'd0; b_addr = 5'd0;
        a_data = '0; b_data = '0;
        Read_addr_1 = 5'd0; Read_addr_2 = 5'd0;

        // Reset state, with every requester asserting.
        rsv_valid = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        #2;
        check("rst_RegWrite", RegWrite, 0);
        check("rst_Write_addr", Write_addr, 0);
        check("rst_Write_data", Write_data, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_rsv_ready", rsv_ready, 0);
        @(posedge clk);
        #3;
        idle();
        rst = 1'b1;
        next_cycle();

        // Reserve r5, then B writes r5.
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        settle();
        check("s1_rsv_ready", rsv_ready, 1);
        next_cycle();
        rsv_valid = 1'b0; Read_addr_1 = 5'd5;
        b_valid = 1'b1; b_addr = 5'd5; b_data = 32'hDEADBEEF;
        settle();
        check("s1_stall_1", stall_1, 1);
        check("s1_b_ready", b_ready, 1);
        check("s1_a_ready", a_ready, 0);
        next_cycle();
        b_valid = 1'b0;
        settle();
        check("s1_RegWrite", RegWrite, 1);
        check("s1_Write_addr", Write_addr, 5);
        check("s1_Write_data", Write_data, 32'hDEADBEEF);
        check("s1_stall_1_wr", stall_1, 1);
        next_cycle();
        settle();
        check("s1_RegWrite_off", RegWrite, 0);
        check("s1_Write_data_hold", Write_data, 32'hDEADBEEF);
        check("s1_stall_1_clr", stall_1, 0);

        // Both requesters held for 6 cycles: B,B,B,A,B,B.
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h0000A0A0;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'h0000B1B1;
        for (int i = 0; i < 6; i++) begin
            settle();
            check($sformatf("s2_b_ready_%0d", i), b_ready, exp_b[i]);
            check($sformatf("s2_a_ready_%0d", i), a_ready, !exp_b[i]);
            if (i > 0) begin
                check($sformatf("s2_Write_addr_%0d", i), Write_addr, exp_b[i-1] ? 11 : 10);
                check($sformatf("s2_RegWrite_%0d", i), RegWrite, 1);
            end
            next_cycle();
        end
        idle();
        settle();
        check("s2_last_Write_addr", Write_addr, 11);
        check("s2_last_Write_data", Write_data, 32'h0000B1B1);
        next_cycle();

        // Double reservation of r7, then reservation colliding with a write of r7.
        Read_addr_1 = 5'd7;
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        settle();
        check("s3_rsv_first", rsv_ready, 1);
        next_cycle();
        settle();
        check("s3_rsv_second", rsv_ready, 0);
        next_cycle();
        rsv_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h00000077;
        settle();
        check("s3_b_ready", b_ready, 1);
        next_cycle();
        b_data = 32'h00000078;
        settle();
        check("s3_wr1_addr", Write_addr, 7);
        check("s3_wr1_stall", stall_1, 1);
        next_cycle();
        b_valid = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        settle();
        check("s3_wr2_RegWrite", RegWrite, 1);
        check("s3_wr2_data", Write_data, 32'h00000078);
        check("s3_nonbusy_stall", stall_1, 0);
        check("s3_rsv_collide", rsv_ready, 1);
        next_cycle();
        rsv_valid = 1'b0;
        settle();
        check("s3_busy7_kept", stall_1, 1);
        check("s3_RegWrite_off", RegWrite, 0);

        // Write to r0 and reservation of r0.
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFFFFFF;
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        Read_addr_1 = 5'd0; Read_addr_2 = 5'd0;
        settle();
        check("s4_a_ready", a_ready, 1);
        check("s4_rsv_ready", rsv_ready, 1);
        check("s4_stall_1", stall_1, 0);
        next_cycle();
        idle();
        settle();
        check("s4_RegWrite", RegWrite, 0);
        check("s4_stall_1_after", stall_1, 0);
        check("s4_stall_2_after", stall_2, 0);

        // Reset with r3 and r9 busy and a write in flight.
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        settle();
        check("s5_rsv3", rsv_ready, 1);
        next_cycle();
        rsv_addr = 5'd9;
        settle();
        check("s5_rsv9", rsv_ready, 1);
        next_cycle();
        rsv_valid = 1'b0;
        Read_addr_1 = 5'd3; Read_addr_2 = 5'd9;
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h00000033;
        settle();
        check("s5_stall_1", stall_1, 1);
        check("s5_stall_2", stall_2, 1);
        check("s5_b_ready", b_ready, 1);
        next_cycle();
        b_addr = 5'd9; b_data = 32'h00000099;
        a_valid = 1'b1; a_addr = 5'd4;
        rsv_valid = 1'b1; rsv_addr = 5'd12;
        settle();
        check("s5_inflight", RegWrite, 1);
        rst = 1'b0;
        #1;
        check("s5_rst_RegWrite", RegWrite, 0);
        check("s5_rst_Write_addr", Write_addr, 0);
        check("s5_rst_Write_data", Write_data, 0);
        check("s5_rst_a_ready", a_ready, 0);
        check("s5_rst_b_ready", b_ready, 0);
        check("s5_rst_rsv_ready", rsv_ready, 0);
        check("s5_rst_stall_1", stall_1, 0);
        check("s5_rst_stall_2", stall_2, 0);
        @(posedge clk);
        #2;
        idle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("s5_post_RegWrite_%0d", i), RegWrite, 0);
            check($sformatf("s5_post_stall_1_%0d", i), stall_1, 0);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 The block SHALL have parameter bit_size, default 32, giving the data width of the write-back path.
REQ-002 The block SHALL have parameter starve_limit, default 3, giving the maximum consecutive denied cycles for requester A; legal range 1..15.
REQ-003 The block SHALL have these ports:
- clk  in  1  the single clock; all state updates on posedge clk.
- rst  in  1  asynchronous, active-low reset.
- rsv_valid  in  1  issue stage requests reservation of a destination register.
- rsv_addr  in  5  destination register to reserve.
- rsv_ready  out  1  reservation accepted this cycle.
- a_valid  in  1  ALU write-back request.
- a_addr  in  5  ALU destination.
- a_data  in  bit_size  ALU result.
- a_ready  out  1  ALU request accepted.
- b_valid  in  1  memory/multicycle write-back request.
- b_addr  in  5  memory/multicycle destination.
- b_data  in  bit_size  memory/multicycle result.
- b_ready  out  1  memory/multicycle request accepted.
- RegWrite  out  1  Regfile write enable.
- Write_addr  out  5  Regfile write address.
- Write_data  out  bit_size  Regfile write data.
- Read_addr_1  in  5  Regfile read address 1, monitored for hazards.
- Read_addr_2  in  5  Regfile read address 2, monitored for hazards.
- stall_1  out  1  Read_addr_1 targets a pending register.
- stall_2  out  1  Read_addr_2 targets a pending register.

Function
REQ-004 The block SHALL grant at most one of a_ready/b_ready per cycle; a transfer occurs on a cycle with valid && ready.
REQ-005 Arbitration SHALL use fixed priority B over A, except that A wins when starve_cnt == starve_limit and a_valid is 1.
REQ-006 starve_cnt SHALL increment, saturating at starve_limit, on each cycle with a_valid=1 and a_ready=0; it SHALL clear on an A transfer or when a_valid=0.
REQ-007 a_ready/b_ready SHALL be combinational from the valids and starve_cnt; a requester SHALL hold addr/data stable while valid && !ready.
REQ-008 A transfer SHALL drive RegWrite=1, Write_addr and Write_data from registers on the following cycle (latency 1); with no transfer, RegWrite=0 and Write_addr/Write_data hold their previous values.
REQ-009 A transfer to address 0 SHALL be accepted but SHALL produce RegWrite=0.
REQ-010 The scoreboard SHALL hold busy[31:1]; busy[0] SHALL be constant 0.
REQ-011 rsv_ready SHALL equal !busy[rsv_addr]; with rsv_addr=0 it SHALL be 1 and change no state.
REQ-012 An accepted reservation SHALL set busy[rsv_addr] at the next edge.
REQ-013 busy[Write_addr] SHALL clear at the edge where RegWrite=1, which is the Regfile write edge.
REQ-014 When a set and a clear hit the same address at the same edge, set SHALL win.
REQ-015 stall_n SHALL be busy[Read_addr_n], combinational.
REQ-016 A write-back to a non-busy address SHALL still be performed with no error indication.

Reset
REQ-017 While rst=0 the block SHALL clear busy, starve_cnt, RegWrite, Write_addr and Write_data to 0 asynchronously, and force a_ready, b_ready and rsv_ready to 0.
REQ-018 After rst deasserts mid-operation, no transfer in flight before reset SHALL produce a Regfile write.

Structure
REQ-019 Shared package regfile_pkg SHALL define bit_size default, REG_ADDR_W=5, NUM_REGS=32 and the starve_limit default.
REQ-020 The scoreboard (busy bits, set/clear, stall lookup) SHALL be sub-module wb_scoreboard; arbitration and the output register SHALL stay in regfile_wb_sched.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reserve r5, then b write r5=0xDEADBEEF: rsv_ready=1; next cycle stall on Read_addr_1=5 is 1; after B transfer, RegWrite=1, Write_addr=5, Write_data=0xDEADBEEF for one cycle, then stall_1=0.
- a_valid and b_valid held 6 cycles, starve_limit=3: grants are B,B,B,A,B,B.
- Reserve r7 twice back-to-back: second rsv_ready=0. Reserve r7 again in the cycle RegWrite=1, Write_addr=7: busy[7] remains 1.
- A write to r0 with a_data=0xFFFFFFFF: a_ready=1, RegWrite stays 0; stall on Read_addr=0 is always 0.
- Assert rst=0 mid-transfer with busy r3 and r9 set: all outputs 0 immediately; after release, stall_1=0 for addr 3 and no RegWrite pulse.
